// File: rtl/note_sequencer_if.sv
// Classifier link: the sequencer (master) drives reset/ok/nota/tom, the classifier (slave) returns fim/tipo.
// cls_ok is a single-cycle qualifier for cls_nota with no back-pressure; cls_fim is level-sampled and ends playback.
interface note_sequencer_if;
    logic       cls_reset;
    logic       cls_ok;
    logic [2:0] cls_nota;
    logic       cls_tom;
    logic       cls_fim;
    logic [1:0] cls_tipo;

    modport master (
        output cls_reset, cls_ok, cls_nota, cls_tom,
        input  cls_fim, cls_tipo
    );

    modport slave (
        input  cls_reset, cls_ok, cls_nota, cls_tom,
        output cls_fim, cls_tipo
    );
endinterface

// File: rtl/note_sequencer.sv
// Buffers keypad notes and replays them to the classifier as evenly spaced cls_ok strobes, then latches tipo.
// Optional macro SEQ_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on the WAIT state.
module note_sequencer #(
    parameter int DEPTH   = 8,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [2:0]          note_in,
    input  logic                tom_in,
    input  logic                play,
    input  logic                clear,
    note_sequencer_if.master    cls,
    output logic                busy,
    output logic                done,
    output logic [1:0]          result,
    output logic [3:0]          count,
    output logic                full,
    output logic                err,
    output logic [2:0]          dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
    localparam logic [3:0]    DEPTH_CNT = 4'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_WAIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [3:0]    idx, idx_next;
    logic [GW-1:0] gap_cnt, gap_next;
    logic [3:0]    count_next;
    logic          err_next, done_next, tom_next, buf_we;
    logic [1:0]    result_next;
    logic [2:0]    mem [DEPTH];

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmr, tmr_next;
`endif

    function automatic logic is_busy(input state_t s);
        return (s == S_CLR) || (s == S_SEND) || (s == S_GAP) || (s == S_WAIT);
    endfunction

    assign dbg_state = state;

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        gap_next    = gap_cnt;
        count_next  = count;
        err_next    = 1'b0;
        done_next   = 1'b0;
        result_next = result;
        tom_next    = cls.cls_tom;
        buf_we      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        tmr_next    = tmr;
`endif
        if (clear) begin
            // clear wins over everything; a simultaneous load is dropped silently
            state_next = S_IDLE;
            count_next = 4'd0;
            idx_next   = 4'd0;
        end else begin
            if (load && is_busy(state)) err_next = 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (play) begin
                        if (count == 4'd0) begin
                            err_next = 1'b1;
                        end else begin
                            tom_next   = tom_in;
                            idx_next   = 4'd0;
                            state_next = S_CLR;
                        end
                        if (load) err_next = 1'b1;
                    end else if (load) begin
                        if (note_in != 3'd0 && !full) begin
                            buf_we     = 1'b1;
                            count_next = count + 4'd1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    state_next = S_SEND;
                end
                S_SEND, S_GAP, S_WAIT: begin
                    if (cls.cls_fim) begin
                        result_next = cls.cls_tipo;
                        done_next   = 1'b1;
                        state_next  = S_DONE;
                    end else if (state == S_SEND) begin
                        gap_next   = GW'(1);
                        state_next = S_GAP;
                    end else if (state == S_GAP) begin
                        if (gap_cnt == GAP_LAST) begin
                            if (idx + 4'd1 == count) begin
                                state_next = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                                tmr_next   = '0;
`endif
                            end else begin
                                idx_next   = idx + 4'd1;
                                state_next = S_SEND;
                            end
                        end else begin
                            gap_next = gap_cnt + GW'(1);
                        end
                    end else begin
`ifdef SEQ_TIMEOUT_EN
                        if (tmr == TMR_LAST) begin
                            result_next = 2'b00;
                            done_next   = 1'b1;
                            err_next    = 1'b1;
                            state_next  = S_DONE;
                        end else begin
                            tmr_next = tmr + TW'(1);
                        end
`else
                        state_next = S_WAIT;
`endif
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= 4'd0;
            gap_cnt       <= '0;
            count         <= 4'd0;
            full          <= 1'b0;
            err           <= 1'b0;
            done          <= 1'b0;
            result        <= 2'd0;
            busy          <= 1'b0;
            cls.cls_reset <= 1'b0;
            cls.cls_ok    <= 1'b0;
            cls.cls_nota  <= 3'd0;
            cls.cls_tom   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 3'd0;
`ifdef SEQ_TIMEOUT_EN
            tmr           <= '0;
`endif
        end else begin
            state         <= state_next;
            idx           <= idx_next;
            gap_cnt       <= gap_next;
            count         <= count_next;
            full          <= (count_next == DEPTH_CNT);
            err           <= err_next;
            done          <= done_next;
            result        <= result_next;
            busy          <= is_busy(state_next);
            cls.cls_reset <= (state_next == S_CLR);
            cls.cls_ok    <= (state_next == S_SEND);
            cls.cls_tom   <= tom_next;
            if (state_next == S_SEND) cls.cls_nota <= mem[idx_next[AW-1:0]];
            if (buf_we) mem[count[AW-1:0]] <= note_in;
`ifdef SEQ_TIMEOUT_EN
            tmr           <= tmr_next;
`endif
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer (DEPTH=8, GAP=4, TIMEOUT=16); inputs change #1 after posedge, outputs sampled there.
module tb_note_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       load, tom_in, play, clear;
    logic [2:0] note_in;
    logic       busy, done, full, err;
    logic [1:0] result;
    logic [3:0] count;
    logic [2:0] dbg_state;
    int         n_checks = 0;
    int         n_errors = 0;

    note_sequencer_if bus ();

    note_sequencer #(.DEPTH(8), .GAP(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .load(load), .note_in(note_in), .tom_in(tom_in),
        .play(play), .clear(clear), .cls(bus), .busy(busy), .done(done),
        .result(result), .count(count), .full(full), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; play = 1'b0; clear = 1'b0; note_in = 3'd0; tom_in = 1'b0;
        bus.cls_fim = 1'b0; bus.cls_tipo = 2'd0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_load(input logic [2:0] n);
        load = 1'b1; note_in = n;
        tick();
        load = 1'b0; note_in = 3'd0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy, done, result, count, full, err, bus.cls_reset, bus.cls_ok, bus.cls_nota, bus.cls_tom, dbg_state} !== 18'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b result=%0d count=%0d full=%0b err=%0b ok=%0b state=%0d, expected all 0",
                     busy, done, result, count, full, err, bus.cls_ok, dbg_state);
        end
    endtask

    task automatic test_play_basic();
        logic [2:0] exp_nota [3];
        exp_nota[0] = 3'd1; exp_nota[1] = 3'd3; exp_nota[2] = 3'd5;
        do_reset();
        do_load(3'd1); do_load(3'd3); do_load(3'd5);
        n_checks++; if (count !== 4'd3) begin n_errors++; $display("FAIL basic_count: got %0d expected 3", count); end
        play = 1'b1; tom_in = 1'b1;
        tick();
        play = 1'b0; tom_in = 1'b0;
        n_checks++;
        if (bus.cls_reset !== 1'b1 || busy !== 1'b1 || bus.cls_ok !== 1'b0) begin
            n_errors++; $display("FAIL basic_clr: got reset=%0b busy=%0b ok=%0b expected 1 1 0", bus.cls_reset, busy, bus.cls_ok);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (bus.cls_ok !== 1'b1 || bus.cls_nota !== exp_nota[k] || bus.cls_reset !== 1'b0) begin
                n_errors++; $display("FAIL basic_strobe%0d: got ok=%0b nota=%0d expected ok=1 nota=%0d", k, bus.cls_ok, bus.cls_nota, exp_nota[k]);
            end
            for (int j = 0; j < 3; j++) begin
                tick();
                n_checks++;
                if (bus.cls_ok !== 1'b0 || bus.cls_nota !== exp_nota[k]) begin
                    n_errors++; $display("FAIL basic_gap%0d_%0d: got ok=%0b nota=%0d expected ok=0 nota=%0d", k, j, bus.cls_ok, bus.cls_nota, exp_nota[k]);
                end
            end
        end
        tick();
        n_checks++;
        if (dbg_state !== 3'd4 || busy !== 1'b1 || bus.cls_tom !== 1'b1) begin
            n_errors++; $display("FAIL basic_wait: got state=%0d busy=%0b tom=%0b expected 4 1 1", dbg_state, busy, bus.cls_tom);
        end
        bus.cls_fim = 1'b1; bus.cls_tipo = 2'd2;
        tick();
        bus.cls_fim = 1'b0; bus.cls_tipo = 2'd0;
        n_checks++;
        if (done !== 1'b1 || result !== 2'd2 || busy !== 1'b0 || dbg_state !== 3'd5) begin
            n_errors++; $display("FAIL basic_done: got done=%0b result=%0d busy=%0b state=%0d expected 1 2 0 5", done, result, busy, dbg_state);
        end
        tick();
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse: got done=%0b expected 0", done); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_load(3'((i % 7) + 1));
            n_checks++;
            if (count !== 4'(i + 1) || full !== (i == 7) || err !== 1'b0) begin
                n_errors++; $display("FAIL full_load%0d: got count=%0d full=%0b err=%0b expected %0d %0b 0", i, count, full, err, i + 1, i == 7);
            end
        end
        do_load(3'd2);
        n_checks++;
        if (err !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
            n_errors++; $display("FAIL full_overflow: got err=%0b count=%0d full=%0b expected 1 8 1", err, count, full);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        n_checks++;
        if (count !== 4'd0 || full !== 1'b0 || err !== 1'b0) begin
            n_errors++; $display("FAIL full_clear: got count=%0d full=%0b err=%0b expected 0 0 0", count, full, err);
        end
        do_load(3'd0);
        n_checks++;
        if (err !== 1'b1 || count !== 4'd0) begin
            n_errors++; $display("FAIL zero_note: got err=%0b count=%0d expected 1 0", err, count);
        end
    endtask

    task automatic test_play_empty();
        play = 1'b1; tick(); play = 1'b0;
        n_checks++;
        if (err !== 1'b1 || bus.cls_reset !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL empty_play: got err=%0b cls_reset=%0b busy=%0b expected 1 0 0", err, bus.cls_reset, busy);
        end
        do_load(3'd2); do_load(3'd4);
        play = 1'b1; load = 1'b1; note_in = 3'd6;
        tick();
        play = 1'b0; load = 1'b0; note_in = 3'd0;
        n_checks++;
        if (err !== 1'b1 || bus.cls_reset !== 1'b1 || busy !== 1'b1 || count !== 4'd2) begin
            n_errors++; $display("FAIL play_load: got err=%0b cls_reset=%0b busy=%0b count=%0d expected 1 1 1 2", err, bus.cls_reset, busy, count);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || bus.cls_reset !== 1'b0 || count !== 4'd0 || dbg_state !== 3'd0) begin
            n_errors++; $display("FAIL clear_clr: got busy=%0b cls_reset=%0b count=%0d state=%0d expected 0 0 0 0", busy, bus.cls_reset, count, dbg_state);
        end
    endtask

    task automatic test_early_fim();
        logic [2:0] seen [$];
        do_reset();
        do_load(3'd1); do_load(3'd2); do_load(3'd3); do_load(3'd4);
        play = 1'b1; tick(); play = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) tick();
        n_checks++;
        if (bus.cls_ok !== 1'b1 || bus.cls_nota !== 3'd2) begin
            n_errors++; $display("FAIL early_strobe1: got ok=%0b nota=%0d expected 1 2", bus.cls_ok, bus.cls_nota);
        end
        tick();
        bus.cls_fim = 1'b1; bus.cls_tipo = 2'd3;
        tick();
        bus.cls_fim = 1'b0; bus.cls_tipo = 2'd0;
        n_checks++;
        if (done !== 1'b1 || result !== 2'd3 || busy !== 1'b0) begin
            n_errors++; $display("FAIL early_done: got done=%0b result=%0d busy=%0b expected 1 3 0", done, result, busy);
        end
        for (int j = 0; j < 10; j++) begin
            tick();
            if (bus.cls_ok === 1'b1) seen.push_back(bus.cls_nota);
        end
        n_checks++;
        if (seen.size() != 0) begin n_errors++; $display("FAIL early_no_more: got %0d strobes expected 0", seen.size()); end
        play = 1'b1; tick(); play = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (bus.cls_ok === 1'b1) seen.push_back(bus.cls_nota);
        end
        n_checks++;
        if (seen.size() != 4) begin
            n_errors++; $display("FAIL replay_count: got %0d strobes expected 4", seen.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (seen[k] !== 3'(k + 1)) begin n_errors++; $display("FAIL replay_note%0d: got %0d expected %0d", k, seen[k], k + 1); end
            end
        end
        tick();
        n_checks++;
        if (dbg_state !== 3'd4) begin n_errors++; $display("FAIL replay_wait: got state=%0d expected 4", dbg_state); end
        bus.cls_fim = 1'b1; bus.cls_tipo = 2'd1;
        tick();
        bus.cls_fim = 1'b0; bus.cls_tipo = 2'd0;
        n_checks++;
        if (done !== 1'b1 || result !== 2'd1) begin
            n_errors++; $display("FAIL replay_done: got done=%0b result=%0d expected 1 1", done, result);
        end
    endtask

    task automatic test_clear_gap();
        int oks = 0;
        clear = 1'b1; tick(); clear = 1'b0;
        do_load(3'd5); do_load(3'd6);
        play = 1'b1; tick(); play = 1'b0;
        tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== 3'd0 || count !== 4'd0 || bus.cls_ok !== 1'b0 || result !== 2'd1) begin
            n_errors++; $display("FAIL clear_gap: got busy=%0b state=%0d count=%0d ok=%0b result=%0d expected 0 0 0 0 1",
                                 busy, dbg_state, count, bus.cls_ok, result);
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            if (bus.cls_ok === 1'b1) oks++;
        end
        n_checks++;
        if (oks != 0) begin n_errors++; $display("FAIL clear_no_ok: got %0d strobes expected 0", oks); end
    endtask

    task automatic test_async_reset();
        do_load(3'd7);
        play = 1'b1; tick(); play = 1'b0;
        tick();
        n_checks++;
        if (bus.cls_ok !== 1'b1) begin n_errors++; $display("FAIL async_pre: got ok=%0b expected 1", bus.cls_ok); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.cls_ok !== 1'b0 || busy !== 1'b0 || bus.cls_reset !== 1'b0 || count !== 4'd0 || result !== 2'd0 || dbg_state !== 3'd0) begin
            n_errors++; $display("FAIL async_reset: got ok=%0b busy=%0b cls_reset=%0b count=%0d result=%0d state=%0d expected all 0",
                                 bus.cls_ok, busy, bus.cls_reset, count, result, dbg_state);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_wait_hold();
        do_reset();
        do_load(3'd3);
        play = 1'b1; tick(); play = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        n_checks++;
        if (dbg_state !== 3'd4) begin n_errors++; $display("FAIL wait_enter: got state=%0d expected 4", dbg_state); end
`ifdef SEQ_TIMEOUT_EN
        for (int j = 0; j < 15; j++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                n_errors++; $display("FAIL timeout_early%0d: got done=%0b busy=%0b expected 0 1", j, done, busy);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || err !== 1'b1 || result !== 2'd0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL timeout_fire: got done=%0b err=%0b result=%0d busy=%0b expected 1 1 0 0", done, err, result, busy);
        end
`else
        for (int j = 0; j < 100; j++) tick();
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || dbg_state !== 3'd4) begin
            n_errors++; $display("FAIL wait_hold: got busy=%0b done=%0b state=%0d expected 1 0 4", busy, done, dbg_state);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_play_basic();
        test_full();
        test_play_empty();
        test_early_fim();
        test_clear_gap();
        test_async_reset();
        test_wait_hold();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Playback controller for the note-classification FSM. It buffers a user-entered note sequence and replays it to the classifier as a clean, evenly spaced stream of single-cycle `ok` strobes. It then waits for the classifier's `fim` and latches the resulting `tipo`. It sits between the note keypad/debounce logic and the classifier, which it owns through a dedicated reset strobe.

## Interface
Parameters:
- `DEPTH`, 8: buffer capacity in notes (2..15).
- `GAP`, 4: cycles between consecutive `cls_ok` strobes (≥2).
- `TIMEOUT`, 16: cycles to wait for `cls_fim` after the last note; used only with `SEQ_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `load`, in, 1: strobe that appends `note_in` to the buffer.
- `note_in`, in, 3: note code; 1=do … 7=si; 0 is invalid.
- `tom_in`, in, 1: tone select, sampled when `play` is accepted.
- `play`, in, 1: strobe that starts replay of the buffer.
- `clear`, in, 1: strobe that empties the buffer; aborts playback if busy.
- `cls_reset`, out, 1: one-cycle reset pulse to the classifier.
- `cls_ok`, out, 1: one-cycle note strobe to the classifier.
- `cls_nota`, out, 3: note presented to the classifier.
- `cls_tom`, out, 1: tone presented to the classifier.
- `cls_fim`, in, 1: classifier finished.
- `cls_tipo`, in, 2: classifier result; 0=invalid, 1=adj, 2=comp, 3=adv.
- `busy`, out, 1: high in CLR, SEND, GAP and WAIT.
- `done`, out, 1: one-cycle pulse when `result` updates.
- `result`, out, 2: last latched `tipo`.
- `count`, out, 4: number of notes held in the buffer.
- `full`, out, 1: `count == DEPTH`.
- `err`, out, 1: one-cycle pulse on any rejected command or timeout.

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, buffer index 0.
- States:
  - **IDLE**: initial state.
  - **CLR**: drives `cls_reset=1`.
  - **SEND**: drives `cls_ok=1` with `cls_nota=buf[idx]`.
  - **GAP**: `cls_ok=0`, `cls_nota` held.
  - **WAIT**: waiting for `cls_fim`.
  - **DONE**: result latched; buffer retained.
- Load rule (IDLE/DONE only):
  - Accepted when `note_in != 0` and not `full`: writes `buf[count]` and increments `count`.
  - Otherwise rejected with an `err` pulse; `count` unchanged.
  - `load` in any busy state is rejected with an `err` pulse.
- Play rule (IDLE/DONE):
  - `count == 0`: `err` pulse, state unchanged.
  - Otherwise: latch `tom_in` into `cls_tom`, set idx=0, go to CLR.
- Sequencing:
  - CLR → SEND.
  - SEND → GAP for `GAP-1` cycles, then idx+1.
  - If idx+1 == `count`: go to WAIT. Otherwise return to SEND.
- `cls_fim` is sampled in SEND, GAP and WAIT. When it is 1:
  - latch `result <= cls_tipo`;
  - pulse `done`;
  - go to DONE, even if notes remain.
- `play` while busy is ignored, with no `err` pulse.
- Priority within one cycle: `clear` > `play` > `load`.
  - `play`+`load` accepts `play`; the load is dropped with an `err` pulse.
  - `clear`+`load` empties the buffer; the load is dropped with no `err` pulse.
- `clear` in any state:
  - sets `count=0` and forces IDLE next cycle;
  - `cls_ok`/`cls_reset` are 0 from the next cycle;
  - `result` is kept.
- DONE behaves like IDLE for commands; `play` replays the same buffer.
- `count` saturates at `DEPTH`; idx never exceeds `count-1`.

## Timing
- `play` sampled at edge t: `cls_reset` high during cycle t+1, first `cls_ok` in cycle t+2.
- Strobe k (0-based) occurs at t+2+k·GAP. The last strobe is at t+2+(count-1)·GAP, and WAIT is entered GAP cycles later.
- `cls_fim` high at edge e: `result`/`done` valid in cycle e+1, and `busy` low in the same cycle.
- Load: `count` and `full` update one cycle after the `load` strobe.
- Asynchronous `reset` mid-playback: `cls_ok`, `busy` and `cls_reset` drop immediately, without waiting for a clock edge.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - WAIT counts cycles. After `TIMEOUT` cycles without `cls_fim`: go to DONE, `result=2'b00`, and pulse both `done` and `err`.
- `SEQ_TIMEOUT_EN` undefined:
  - WAIT holds indefinitely until `cls_fim` arrives or `clear`/`reset` is applied. No timeout counter is built.

## Test plan
- Load 1,3,5 then `play` with GAP=4 → `cls_reset` at t+1; `cls_ok` at t+2, t+6, t+10 with `cls_nota` 1,3,5. Model drives `cls_fim=1`, `tipo=2` → `result=2`, one `done` pulse, `busy` low.
- Load 9 notes with DEPTH=8 → `full=1` after the 8th; the 9th load pulses `err` and `count` stays at 8. `note_in=0` also pulses `err`.
- `play` with empty buffer → `err` pulse, no `cls_reset`, `busy` stays 0. Same-cycle `play`+`load` with count=2 → playback starts, `err` pulses, `count` stays 2.
- `cls_fim` asserted after the 2nd of 4 strobes → DONE immediately and no 3rd `cls_ok`. A second `play` replays all 4 notes.
- `clear` during GAP → IDLE next cycle, `count=0`, no further `cls_ok`. Async `reset` mid-SEND → all outputs 0 immediately.
- With `SEQ_TIMEOUT_EN`, TIMEOUT=16, no `cls_fim` → 16 cycles after entering WAIT: `result=0`, `done` and `err` pulse together. Without the macro, `busy` remains high after 100 cycles.
